// File: rtl/ram_access_arbiter_pkg.sv
// ram_access_arbiter_pkg: shared encodings and default widths for the RAM access arbiter
package ram_access_arbiter_pkg;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int INST_W     = 16;
    localparam int STARVE_MAX = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic [1:0] {
        MEM_OP_RD  = 2'b00,
        MEM_OP_WR  = 2'b01,
        MEM_OP_IWR = 2'b10,
        MEM_OP_NOP = 2'b11
    } mem_op_t;
endpackage

// File: rtl/ram_arb_priority.sv
// ram_arb_priority: picks the grant winner for a free slot; memory wins ties unless fetch is starved
// Ports: Clk, Rst_n (async, active-low); Slot = a grant may be issued this cycle;
//        Fetch_Req/Mem_Req = requests; Fetch_Win/Mem_Win = one-hot winner (combinational).
module ram_arb_priority #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Slot,
    input  logic Fetch_Req,
    input  logic Mem_Req,
    output logic Fetch_Win,
    output logic Mem_Win
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve;
    assign Fetch_Win = Slot && Fetch_Req && (!Mem_Req || starve == CW'(STARVE_LIMIT));
    assign Mem_Win   = Slot && Mem_Req && !Fetch_Win;
    // Counts slots fetch wanted but lost; saturates so fetch keeps winning until it is served.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            starve <= '0;
        else if (Fetch_Win)
            starve <= '0;
        else if (Mem_Win && Fetch_Req && starve != CW'(STARVE_LIMIT))
            starve <= starve + 1'b1;
    end
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares the unified inst/data RAM between instruction fetch and the memory/loader port
// Ports: Clk, Rst_n (async, active-low)
//        Fetch_Req/Addr in, Fetch_Gnt/Valid/Inst out           - fetch requester
//        Mem_Req/Op/Addr/Wdata/Winst in, Mem_Gnt/Valid/Rdata out - memory/loader requester
//        Ram_* strobes, Ram_Addr, Inst_Addr, Ram_Data_In, Ram_Inst_In out; Ram_Data_Out, Ram_Inst_Out in
//        Busy out - an access is in ACCESS or RESP
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int DATA_WIDTH   = DATA_W,
    parameter int INST_WIDTH   = INST_W,
    parameter int STARVE_LIMIT = STARVE_MAX
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Fetch_Req,
    input  logic [ADDR_WIDTH-1:0] Fetch_Addr,
    output logic                  Fetch_Gnt,
    output logic                  Fetch_Valid,
    output logic [INST_WIDTH-1:0] Fetch_Inst,
    input  logic                  Mem_Req,
    input  logic [1:0]            Mem_Op,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [DATA_WIDTH-1:0] Mem_Wdata,
    input  logic [INST_WIDTH-1:0] Mem_Winst,
    output logic                  Mem_Gnt,
    output logic                  Mem_Valid,
    output logic [DATA_WIDTH-1:0] Mem_Rdata,
    output logic                  Ram_Data_Read,
    output logic                  Ram_Data_Write,
    output logic                  Ram_Inst_Read,
    output logic                  Ram_Inst_Write,
    output logic [ADDR_WIDTH-1:0] Ram_Addr,
    output logic [ADDR_WIDTH-1:0] Inst_Addr,
    output logic [DATA_WIDTH-1:0] Ram_Data_In,
    output logic [INST_WIDTH-1:0] Ram_Inst_In,
    input  logic [DATA_WIDTH-1:0] Ram_Data_Out,
    input  logic [INST_WIDTH-1:0] Ram_Inst_Out,
    output logic                  Busy
);
    state_t                state;
    mem_op_t               op;
    logic                  own_fetch;
    logic                  live;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  slot;
    // live holds grants off until the first edge after reset, so nothing is granted while Rst_n is low.
    assign slot = live && state != ST_ACCESS;
    ram_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Slot      (slot),
        .Fetch_Req (Fetch_Req),
        .Mem_Req   (Mem_Req),
        .Fetch_Win (Fetch_Gnt),
        .Mem_Win   (Mem_Gnt)
    );
    assign Ram_Addr   = addr;
    assign Inst_Addr  = addr;
    assign Busy       = state != ST_IDLE;
    // RAM read data arrives in RESP, one cycle after the read strobe.
    assign Fetch_Inst = Fetch_Valid ? Ram_Inst_Out : '0;
    assign Mem_Rdata  = (Mem_Valid && op == MEM_OP_RD) ? Ram_Data_Out : '0;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= ST_IDLE;
            op             <= MEM_OP_NOP;
            own_fetch      <= 1'b0;
            live           <= 1'b0;
            addr           <= '0;
            Ram_Data_In    <= '0;
            Ram_Inst_In    <= '0;
            Ram_Data_Read  <= 1'b0;
            Ram_Data_Write <= 1'b0;
            Ram_Inst_Read  <= 1'b0;
            Ram_Inst_Write <= 1'b0;
            Fetch_Valid    <= 1'b0;
            Mem_Valid      <= 1'b0;
        end else begin
            live           <= 1'b1;
            state          <= state == ST_ACCESS ? ST_RESP : (Fetch_Gnt || Mem_Gnt) ? ST_ACCESS : ST_IDLE;
            Fetch_Valid    <= state == ST_ACCESS && own_fetch;
            Mem_Valid      <= state == ST_ACCESS && !own_fetch;
            Ram_Inst_Read  <= Fetch_Gnt;
            Ram_Data_Read  <= Mem_Gnt && Mem_Op == MEM_OP_RD;
            Ram_Data_Write <= Mem_Gnt && Mem_Op == MEM_OP_WR;
            Ram_Inst_Write <= Mem_Gnt && Mem_Op == MEM_OP_IWR;
            if (Fetch_Gnt) begin
                own_fetch <= 1'b1;
                addr      <= Fetch_Addr;
            end
            if (Mem_Gnt) begin
                own_fetch <= 1'b0;
                op        <= mem_op_t'(Mem_Op);
                addr      <= Mem_Addr;
            end
            if (Mem_Gnt && Mem_Op == MEM_OP_WR)
                Ram_Data_In <= Mem_Wdata;
            if (Mem_Gnt && Mem_Op == MEM_OP_IWR)
                Ram_Inst_In <= Mem_Winst;
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: scoreboard bench for ram_access_arbiter with a registered-read RAM model
module tb_ram_access_arbiter;
    logic        Clk = 0;
    logic        Rst_n = 0;
    logic        Fetch_Req = 0;
    logic [7:0]  Fetch_Addr = 0;
    logic        Fetch_Gnt, Fetch_Valid;
    logic [15:0] Fetch_Inst;
    logic        Mem_Req = 0;
    logic [1:0]  Mem_Op = 0;
    logic [7:0]  Mem_Addr = 0;
    logic [7:0]  Mem_Wdata = 0;
    logic [15:0] Mem_Winst = 0;
    logic        Mem_Gnt, Mem_Valid;
    logic [7:0]  Mem_Rdata;
    logic        Ram_Data_Read, Ram_Data_Write, Ram_Inst_Read, Ram_Inst_Write;
    logic [7:0]  Ram_Addr, Inst_Addr, Ram_Data_In;
    logic [15:0] Ram_Inst_In;
    logic [7:0]  Ram_Data_Out = 0;
    logic [15:0] Ram_Inst_Out = 0;
    logic        Busy;

    ram_access_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Fetch_Req(Fetch_Req), .Fetch_Addr(Fetch_Addr), .Fetch_Gnt(Fetch_Gnt),
        .Fetch_Valid(Fetch_Valid), .Fetch_Inst(Fetch_Inst),
        .Mem_Req(Mem_Req), .Mem_Op(Mem_Op), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
        .Mem_Winst(Mem_Winst), .Mem_Gnt(Mem_Gnt), .Mem_Valid(Mem_Valid), .Mem_Rdata(Mem_Rdata),
        .Ram_Data_Read(Ram_Data_Read), .Ram_Data_Write(Ram_Data_Write),
        .Ram_Inst_Read(Ram_Inst_Read), .Ram_Inst_Write(Ram_Inst_Write),
        .Ram_Addr(Ram_Addr), .Inst_Addr(Inst_Addr), .Ram_Data_In(Ram_Data_In),
        .Ram_Inst_In(Ram_Inst_In), .Ram_Data_Out(Ram_Data_Out), .Ram_Inst_Out(Ram_Inst_Out),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    logic [7:0]  ram_d [256];
    logic [15:0] ram_i [256];
    logic [7:0]  shd_d [256];
    logic [15:0] shd_i [256];

    always @(posedge Clk) begin
        if (Ram_Data_Write) ram_d[Ram_Addr] <= Ram_Data_In;
        if (Ram_Inst_Write) ram_i[Inst_Addr] <= Ram_Inst_In;
        if (Ram_Data_Read) Ram_Data_Out <= ram_d[Ram_Addr];
        if (Ram_Inst_Read) Ram_Inst_Out <= ram_i[Inst_Addr];
    end

    typedef struct {
        int          cyc;
        bit          f;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  wd;
        logic [15:0] wi;
        logic [31:0] data;
    } item_t;

    item_t sb [$];
    item_t pend;
    bit    pend_v = 0;
    bit    mon_en = 0;
    int    cyc = 0;
    int    gcyc [$];
    byte   glog [$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] strobe_of(item_t it);
        if (it.f) return 4'b1000;
        case (it.op)
            2'b00:   return 4'b0100;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: strobes one cycle after a grant, response two cycles after, in grant order.
    always @(negedge Clk) if (mon_en) begin
        item_t it;
        chk("strobe", {28'd0, Ram_Inst_Read, Ram_Data_Read, Ram_Data_Write, Ram_Inst_Write},
            pend_v ? {28'd0, strobe_of(pend)} : 32'd0);
        if (pend_v) begin
            chk("ram_addr", {24'd0, Ram_Addr}, {24'd0, pend.a});
            chk("inst_addr", {24'd0, Inst_Addr}, {24'd0, pend.a});
            chk("busy", {31'd0, Busy}, 1);
            if (!pend.f && pend.op == 2'b01) chk("data_in", {24'd0, Ram_Data_In}, {24'd0, pend.wd});
            if (!pend.f && pend.op == 2'b10) chk("inst_in", {16'd0, Ram_Inst_In}, {16'd0, pend.wi});
        end
        pend_v = 0;
        if (Fetch_Valid || Mem_Valid) begin
            if (sb.size() == 0) chk("spurious_valid", {30'd0, Fetch_Valid, Mem_Valid}, 0);
            else begin
                it = sb.pop_front();
                chk("owner", {30'd0, Fetch_Valid, Mem_Valid}, it.f ? 32'd2 : 32'd1);
                chk("latency", cyc - it.cyc, 2);
                chk(it.f ? "fetch_inst" : "mem_rdata", it.f ? {16'd0, Fetch_Inst} : {24'd0, Mem_Rdata}, it.data);
            end
        end else if (sb.size() != 0 && cyc - sb[0].cyc > 2) begin
            chk("resp_timeout", cyc - sb[0].cyc, 2);
            void'(sb.pop_front());
        end
        if (Fetch_Gnt || Mem_Gnt) begin
            chk("gnt_onehot", {31'd0, Fetch_Gnt & Mem_Gnt}, 0);
            it.cyc = cyc;
            it.f   = Fetch_Gnt;
            it.op  = Mem_Op;
            it.a   = Fetch_Gnt ? Fetch_Addr : Mem_Addr;
            it.wd  = Mem_Wdata;
            it.wi  = Mem_Winst;
            if (it.f) it.data = {16'd0, shd_i[it.a]};
            else if (it.op == 2'b00) it.data = {24'd0, shd_d[it.a]};
            else it.data = 0;
            if (!it.f && it.op == 2'b01) shd_d[it.a] = it.wd;
            if (!it.f && it.op == 2'b10) shd_i[it.a] = it.wi;
            sb.push_back(it);
            pend = it;
            pend_v = 1;
            gcyc.push_back(cyc);
            glog.push_back(it.f ? "F" : "M");
        end
    end

    task automatic mem_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd, input logic [15:0] wi);
        int n = 0;
        Mem_Req = 1; Mem_Op = op; Mem_Addr = a; Mem_Wdata = wd; Mem_Winst = wi;
        do begin @(negedge Clk); n++; end while (!Mem_Gnt && n < 40);
        if (!Mem_Gnt) chk("mem_gnt_timeout", 0, 1);
        @(posedge Clk); #1;
        Mem_Req = 0;
    endtask

    task automatic fetch_op(input logic [7:0] a);
        int n = 0;
        Fetch_Req = 1; Fetch_Addr = a;
        do begin @(negedge Clk); n++; end while (!Fetch_Gnt && n < 40);
        if (!Fetch_Gnt) chk("fetch_gnt_timeout", 0, 1);
        @(posedge Clk); #1;
        Fetch_Req = 0;
    endtask

    function automatic logic all_out_or();
        return |{Fetch_Gnt, Fetch_Valid, Fetch_Inst, Mem_Gnt, Mem_Valid, Mem_Rdata,
                 Ram_Data_Read, Ram_Data_Write, Ram_Inst_Read, Ram_Inst_Write,
                 Ram_Addr, Inst_Addr, Ram_Data_In, Ram_Inst_In, Busy};
    endfunction

    initial begin
        int n0;
        int n;
        for (int i = 0; i < 256; i++) begin
            ram_d[i] = 8'(i * 7 + 1);
            ram_i[i] = 16'(i * 257 + 'h11);
            shd_d[i] = ram_d[i];
            shd_i[i] = ram_i[i];
        end
        Fetch_Req = 1; Mem_Req = 1;
        repeat (3) @(negedge Clk);
        chk("in_reset_outputs", {31'd0, all_out_or()}, 0);
        Fetch_Req = 0; Mem_Req = 0;
        Rst_n = 1;
        @(negedge Clk);
        chk("post_reset_outputs", {31'd0, all_out_or()}, 0);
        @(posedge Clk); #1;
        // Reset asserted in the middle of an access.
        Mem_Req = 1; Mem_Op = 2'b00; Mem_Addr = 8'd7;
        @(negedge Clk);
        chk("rst_pre_gnt", {31'd0, Mem_Gnt}, 1);
        @(posedge Clk); #1;
        Mem_Req = 0;
        @(negedge Clk);
        chk("rst_pre_strobe", {31'd0, Ram_Data_Read}, 1);
        Rst_n = 0;
        #1;
        chk("rst_strobes_drop", {28'd0, Ram_Inst_Read, Ram_Data_Read, Ram_Data_Write, Ram_Inst_Write}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        repeat (3) begin
            @(negedge Clk);
            chk("rst_no_valid", {30'd0, Fetch_Valid, Mem_Valid}, 0);
        end
        Rst_n = 1;
        repeat (2) @(negedge Clk);
        chk("rst_release_outputs", {31'd0, all_out_or()}, 0);
        @(posedge Clk); #1;
        sb.delete(); pend_v = 0; mon_en = 1;
        // Fetch only.
        fetch_op(8'd5);
        repeat (3) @(posedge Clk); #1;
        // Data write then back-to-back data read of the same address.
        n0 = gcyc.size();
        mem_op(2'b01, 8'd9, 8'h2A, 16'h0);
        mem_op(2'b00, 8'd9, 8'h0, 16'h0);
        chk("b2b_gap", gcyc[n0 + 1] - gcyc[n0], 2);
        repeat (3) @(posedge Clk); #1;
        // Instruction write, fetch it back, data field untouched.
        mem_op(2'b10, 8'd3, 8'h0, 16'hBEEF);
        fetch_op(8'd3);
        mem_op(2'b00, 8'd3, 8'h0, 16'h0);
        repeat (3) @(posedge Clk); #1;
        // No-op.
        mem_op(2'b11, 8'd12, 8'h55, 16'h1234);
        repeat (3) @(posedge Clk); #1;
        // Wrap-around address.
        mem_op(2'b01, 8'hFF, 8'hC3, 16'h0);
        mem_op(2'b00, 8'hFF, 8'h0, 16'h0);
        repeat (3) @(posedge Clk); #1;
        // Contention: memory wins four slots, then fetch is forced through.
        n0 = gcyc.size();
        glog.delete();
        fork
            for (int i = 0; i < 8; i++) mem_op(2'(i % 2), 8'(20 + i), 8'(i + 'h40), 16'h0);
            for (int j = 0; j < 2; j++) fetch_op(8'(100 + j));
        join
        chk("contend_grants", glog.size(), 10);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            chk($sformatf("contend_slot%0d", k), {24'd0, glog[k]}, (k % 5 == 4) ? "F" : "M");
        if (gcyc.size() >= n0 + 10) chk("contend_no_idle_slot", gcyc[n0 + 9] - gcyc[n0], 18);
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge Clk); n++; end
        repeat (2) @(posedge Clk);
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
